// File: rtl/ps2_pkg.sv
// Shared PS/2 definitions: frame FSM states, frame length and parity helper.
// Used by both the host transmit and device receive paths.
package ps2_pkg;

    typedef enum logic [2:0] {
        IDLE,
        INHIBIT,
        REQ,
        DATA,
        PARITY,
        STOP,
        ACK,
        WAIT_IDLE
    } ps2_state_e;

    localparam int unsigned PS2_FRAME_BITS = 11;

    function automatic logic odd_parity(input logic [7:0] data);
        return ~^data;
    endfunction

endpackage

// File: rtl/ps2_line_sync.sv
// Multi-stage synchronizer with falling-edge detect for one PS/2 line.
// Chain and edge history reset to 1, matching an idle (pulled-up) line.
module ps2_line_sync #(
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic reset,
    input  logic line_in,
    output logic line_sync,
    output logic line_fe
);

    logic [SYNC_STAGES-1:0] sync_q, sync_d;
    logic                   prev_q, prev_d;

    always_comb begin
        sync_d    = sync_q;
        sync_d[0] = line_in;
        for (int unsigned i = 1; i < SYNC_STAGES; i++) begin
            sync_d[i] = sync_q[i-1];
        end
        prev_d = sync_q[SYNC_STAGES-1];
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            sync_q <= '1;
            prev_q <= 1'b1;
        end else begin
            sync_q <= sync_d;
            prev_q <= prev_d;
        end
    end

    assign line_sync = sync_q[SYNC_STAGES-1];
    assign line_fe   = prev_q & ~sync_q[SYNC_STAGES-1];

endmodule

// File: rtl/ps2_host_tx.sv
// Host-to-device PS/2 transmitter: request-to-send, frame shift, ack check.
// Define PS2_HOST_TX_TIMEOUT_EN to enable the device-clock watchdog.
module ps2_host_tx
    import ps2_pkg::*;
#(
    parameter int unsigned INHIBIT_CYCLES = 10000,
    parameter int unsigned TIMEOUT_CYCLES = 200000,
    parameter int unsigned SYNC_STAGES    = 2
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       tx_valid,
    input  logic [7:0] tx_data,
    output logic       tx_ready,
    input  logic       ps2_clk_in,
    input  logic       ps2_data_in,
    output logic       ps2_clk_oe,
    output logic       ps2_data_oe,
    output logic       tx_done,
    output logic       tx_err
);

    if (INHIBIT_CYCLES < 2 || TIMEOUT_CYCLES < 2 || SYNC_STAGES < 2) begin : g_param_check
        $error("ps2_host_tx: INHIBIT_CYCLES, TIMEOUT_CYCLES and SYNC_STAGES must be >= 2");
    end

    localparam int unsigned    CNT_W    = $clog2(INHIBIT_CYCLES);
    localparam logic [CNT_W-1:0] INH_LAST = CNT_W'(INHIBIT_CYCLES - 1);
    localparam logic [CNT_W-1:0] INH_DATA = CNT_W'(INHIBIT_CYCLES - 2);

    logic clk_sync, clk_fe;
    logic data_sync, data_fe_unused;

    ps2_line_sync #(.SYNC_STAGES(SYNC_STAGES)) u_clk_sync (
        .clk       (clk),
        .reset     (reset),
        .line_in   (ps2_clk_in),
        .line_sync (clk_sync),
        .line_fe   (clk_fe)
    );

    ps2_line_sync #(.SYNC_STAGES(SYNC_STAGES)) u_data_sync (
        .clk       (clk),
        .reset     (reset),
        .line_in   (ps2_data_in),
        .line_sync (data_sync),
        .line_fe   (data_fe_unused)
    );

    ps2_state_e       state_q, state_d;
    logic [7:0]       byte_q, byte_d;
    logic             parity_q, parity_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [2:0]       bitcnt_q, bitcnt_d;
    logic             ok_q, ok_d;
    logic             clk_oe_q, clk_oe_d;
    logic             data_oe_q, data_oe_d;
    logic             done_q, done_d;
    logic             err_q, err_d;
    logic             ready_q, ready_d;

`ifdef PS2_HOST_TX_TIMEOUT_EN
    localparam int unsigned      WD_W    = $clog2(TIMEOUT_CYCLES);
    localparam logic [WD_W-1:0] WD_LAST = WD_W'(TIMEOUT_CYCLES - 1);
    logic [WD_W-1:0] wd_q, wd_d;
`endif

    always_comb begin
        state_d   = state_q;
        byte_d    = byte_q;
        parity_d  = parity_q;
        cnt_d     = cnt_q;
        bitcnt_d  = bitcnt_q;
        ok_d      = ok_q;
        clk_oe_d  = clk_oe_q;
        data_oe_d = data_oe_q;
        done_d    = 1'b0;
        err_d     = 1'b0;
        // Held low through the pulse cycle so tx_ready rises one cycle after it.
        ready_d   = (state_q == IDLE);

        case (state_q)
            IDLE: begin
                clk_oe_d  = 1'b0;
                data_oe_d = 1'b0;
                if (tx_valid && ready_q) begin
                    byte_d   = tx_data;
                    parity_d = odd_parity(tx_data);
                    cnt_d    = '0;
                    clk_oe_d = 1'b1;
                    ready_d  = 1'b0;
                    state_d  = INHIBIT;
                end
            end
            INHIBIT: begin
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == INH_DATA) data_oe_d = 1'b1;
                if (cnt_q == INH_LAST) begin
                    clk_oe_d = 1'b0;
                    state_d  = REQ;
                end
            end
            REQ: begin
                // First device fall already shifts d0, so DATA resumes at bit 1.
                if (clk_fe) begin
                    data_oe_d = ~byte_q[0];
                    bitcnt_d  = 3'd1;
                    state_d   = DATA;
                end
            end
            DATA: begin
                if (clk_fe) begin
                    data_oe_d = ~byte_q[bitcnt_q];
                    bitcnt_d  = bitcnt_q + 3'd1;
                    if (bitcnt_q == 3'd7) state_d = PARITY;
                end
            end
            PARITY: begin
                if (clk_fe) begin
                    data_oe_d = ~parity_q;
                    state_d   = STOP;
                end
            end
            STOP: begin
                if (clk_fe) begin
                    data_oe_d = 1'b0;
                    state_d   = ACK;
                end
            end
            ACK: begin
                if (clk_fe) begin
                    ok_d    = ~data_sync;
                    state_d = WAIT_IDLE;
                end
            end
            WAIT_IDLE: begin
                if (clk_sync && data_sync) begin
                    done_d  = ok_q;
                    err_d   = ~ok_q;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

`ifdef PS2_HOST_TX_TIMEOUT_EN
        if (state_q == IDLE || state_q == INHIBIT || clk_fe) begin
            wd_d = '0;
        end else begin
            wd_d = wd_q + 1'b1;
        end
        if (state_q != IDLE && state_q != INHIBIT && !clk_fe && wd_q == WD_LAST) begin
            wd_d      = '0;
            clk_oe_d  = 1'b0;
            data_oe_d = 1'b0;
            done_d    = 1'b0;
            err_d     = 1'b1;
            ready_d   = 1'b0;
            state_d   = IDLE;
        end
`endif
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q   <= IDLE;
            byte_q    <= '0;
            parity_q  <= 1'b0;
            cnt_q     <= '0;
            bitcnt_q  <= '0;
            ok_q      <= 1'b0;
            clk_oe_q  <= 1'b0;
            data_oe_q <= 1'b0;
            done_q    <= 1'b0;
            err_q     <= 1'b0;
            ready_q   <= 1'b1;
`ifdef PS2_HOST_TX_TIMEOUT_EN
            wd_q      <= '0;
`endif
        end else begin
            state_q   <= state_d;
            byte_q    <= byte_d;
            parity_q  <= parity_d;
            cnt_q     <= cnt_d;
            bitcnt_q  <= bitcnt_d;
            ok_q      <= ok_d;
            clk_oe_q  <= clk_oe_d;
            data_oe_q <= data_oe_d;
            done_q    <= done_d;
            err_q     <= err_d;
            ready_q   <= ready_d;
`ifdef PS2_HOST_TX_TIMEOUT_EN
            wd_q      <= wd_d;
`endif
        end
    end

    assign tx_ready    = ready_q;
    assign ps2_clk_oe  = clk_oe_q;
    assign ps2_data_oe = data_oe_q;
    assign tx_done     = done_q;
    assign tx_err      = err_q;

endmodule

// File: tb/tb_ps2_host_tx.sv
// Directed/random bench for ps2_host_tx with an open-drain device model.
// Build with PS2_HOST_TX_TIMEOUT_EN to also exercise the watchdog.
module tb_ps2_host_tx;

    logic       clk;
    logic       reset;
    logic       tx_valid;
    logic [7:0] tx_data;
    logic       tx_ready;
    logic       ps2_clk_in;
    logic       ps2_data_in;
    logic       ps2_clk_oe;
    logic       ps2_data_oe;
    logic       tx_done;
    logic       tx_err;

    logic bfm_clk;
    logic bfm_data_low;

    int vectors     = 0;
    int miscompares = 0;
    int done_cnt    = 0;
    int err_cnt     = 0;
    bit both_seen   = 0;

    assign ps2_clk_in  = bfm_clk & ~ps2_clk_oe;
    assign ps2_data_in = ~bfm_data_low & ~ps2_data_oe;

    ps2_host_tx #(
        .INHIBIT_CYCLES (16),
        .TIMEOUT_CYCLES (64),
        .SYNC_STAGES    (2)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .tx_valid    (tx_valid),
        .tx_data     (tx_data),
        .tx_ready    (tx_ready),
        .ps2_clk_in  (ps2_clk_in),
        .ps2_data_in (ps2_data_in),
        .ps2_clk_oe  (ps2_clk_oe),
        .ps2_data_oe (ps2_data_oe),
        .tx_done     (tx_done),
        .tx_err      (tx_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (tx_done) done_cnt++;
        if (tx_err) err_cnt++;
        if (tx_done && tx_err) both_seen = 1'b1;
    end

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Wire order as the device sees it: d0..d7, odd parity, stop.
    function automatic logic [9:0] model_bits(input logic [7:0] b);
        int ones = 0;
        for (int i = 0; i < 8; i++) ones += int'(b[i]);
        return {1'b1, (ones % 2 == 0), b};
    endfunction

    task automatic run_frame(input logic [7:0] b, input bit ack,
                             input int inject_k, input int reset_k, input int stop_k);
        logic [9:0] exp_bits;
        logic [9:0] got_bits;
        int         n;
        int         first_data;
        int         since;
        int         dc0;
        int         ec0;
        bit         aborted;
        exp_bits = model_bits(b);
        got_bits = '0;
        aborted  = 1'b0;
        dc0      = done_cnt;
        ec0      = err_cnt;

        n = 0;
        while (!tx_ready && n < 200) begin cyc(1); n++; end
        chk("ready_idle", tx_ready, 1);
        tx_valid = 1'b1;
        tx_data  = b;
        cyc(1);
        tx_valid = 1'b0;
        tx_data  = 8'($urandom);
        chk("ready_drop", tx_ready, 0);

        n = 0;
        first_data = -1;
        while (ps2_clk_oe && n < 1000) begin
            if (ps2_data_oe && first_data < 0) first_data = n;
            n++;
            cyc(1);
        end
        chk("inhibit_len", n, 16);
        chk("start_at_last_inhibit", first_data, 15);
        chk("start_bit_pin", ps2_data_in, 0);

        cyc(4);
        for (int k = 1; k <= 11 && !aborted; k++) begin
            bfm_clk = 1'b0;
            for (int j = 0; j < 20; j++) begin
                cyc(1);
                if (k == inject_k && j == 5) begin tx_valid = 1'b1; tx_data = 8'h55; end
                if (k == inject_k && j == 6) tx_valid = 1'b0;
                if (k == reset_k && j == 10) reset = 1'b0;
                if (k == reset_k && j == 11) begin
                    reset   = 1'b1;
                    bfm_clk = 1'b1;
                    aborted = 1'b1;
                    chk("rst_clk_oe", ps2_clk_oe, 0);
                    chk("rst_data_oe", ps2_data_oe, 0);
                    chk("rst_ready", tx_ready, 1);
                    chk("rst_no_pulse", {tx_done, tx_err}, 0);
                    break;
                end
            end
            if (!aborted) begin
                if (k <= 10) got_bits[k-1] = ps2_data_in;
                bfm_clk = 1'b1;
                if (k == 10 && ack) bfm_data_low = 1'b1;
                if (k == stop_k) begin
                    since = 20;
                    while (!tx_err && since < 300) begin cyc(1); since++; end
                    chk("timeout_window", (since >= 64 && since <= 68), 1);
                    chk("timeout_clk_oe", ps2_clk_oe, 0);
                    chk("timeout_data_oe", ps2_data_oe, 0);
                    aborted = 1'b1;
                end else if (k < 11) begin
                    cyc(20);
                end
            end
        end
        bfm_data_low = 1'b0;

        if (reset_k == 0 && stop_k == 0) begin
            n = 0;
            while (!(tx_done || tx_err) && n < 200) begin cyc(1); n++; end
            chk("pulse_done", tx_done, ack);
            chk("pulse_err", tx_err, !ack);
            chk("ready_in_pulse", tx_ready, 0);
            cyc(1);
            chk("ready_return", tx_ready, 1);
            chk("wire_bits", got_bits, exp_bits);
        end
        cyc(3);
        chk("done_count", done_cnt - dc0, (reset_k == 0 && stop_k == 0 && ack));
        chk("err_count", err_cnt - ec0, (reset_k == 0 && (stop_k != 0 || !ack)));
    endtask

    initial begin
        logic [7:0] rb;
        bit         ra;
        bit         seen;
        reset        = 1'b0;
        tx_valid     = 1'b0;
        tx_data      = 8'h00;
        bfm_clk      = 1'b1;
        bfm_data_low = 1'b0;
        cyc(3);
        chk("reset_ready", tx_ready, 1);
        chk("reset_clk_oe", ps2_clk_oe, 0);
        chk("reset_data_oe", ps2_data_oe, 0);
        chk("reset_pulses", {tx_done, tx_err}, 0);
        reset = 1'b1;
        cyc(5);

        run_frame(8'hED, 1'b1, 0, 0, 0);
        run_frame(8'h00, 1'b1, 0, 0, 0);
        run_frame(8'hFF, 1'b0, 0, 0, 0);

        run_frame(8'hF4, 1'b1, 3, 0, 0);
        seen = 1'b0;
        for (int i = 0; i < 40; i++) begin cyc(1); seen |= ps2_clk_oe; end
        chk("dropped_not_queued", seen, 0);

        for (int i = 0; i < 3; i++) begin
            rb = 8'($urandom);
            ra = 1'($urandom_range(0, 1));
            run_frame(rb, ra, 0, 0, 0);
        end

        run_frame(8'($urandom), 1'b1, 0, 5, 0);
        run_frame(8'($urandom), 1'b1, 0, 0, 0);

`ifdef PS2_HOST_TX_TIMEOUT_EN
        run_frame(8'($urandom), 1'b1, 0, 0, 3);
        run_frame(8'($urandom), 1'b1, 0, 0, 0);
`endif

        chk("never_both_pulses", both_seen, 0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
